i2s_tdm_ws_gen: RTL and testbench

I2S_TDM_WS_GEN -- requirements
Module: i2s_tdm_ws_gen

---
 rtl/i2s_ws_pkg.sv | 21 ++
 rtl/i2s_ws_frame_cnt.sv | 48 ++++
 rtl/i2s_tdm_ws_gen.sv | 183 ++++++++++++++++++
 tb/tb_i2s_tdm_ws_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_ws_pkg.sv
// rtl/i2s_ws_pkg.sv - shared types and default widths for the I2S/TDM word-select generator
package i2s_ws_pkg;

    localparam int DEF_MAX_BITS_W  = 5;
    localparam int DEF_MAX_SLOTS_W = 4;
    localparam int DEF_SETUP_W     = 16;

    typedef enum logic [1:0] {
        I2S       = 2'b00,
        LJ        = 2'b01,
        DSP_SHORT = 2'b10,
        DSP_LONG  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/i2s_ws_frame_cnt.sv
// rtl/i2s_ws_frame_cnt.sv - bit/slot position counter with frame-end flag
module i2s_ws_frame_cnt #(
    parameter int BITS_W  = 5,
    parameter int SLOTS_W = 4
) (
    input  logic               sck_i,
    input  logic               rstn_i,
    input  logic               clr_i,
    input  logic [BITS_W-1:0]  num_bits_i,
    input  logic [SLOTS_W-1:0] num_words_i,
    output logic [BITS_W-1:0]  bit_nxt_o,
    output logic [SLOTS_W-1:0] slot_nxt_o,
    output logic               frame_end_o
);

    logic [BITS_W-1:0]  bit_q;
    logic [SLOTS_W-1:0] slot_q;
    logic               last_bit;

    // Next position: clear forces p=0, otherwise step with wrap at N and W
    always_comb begin
        last_bit    = (bit_q == num_bits_i);
        frame_end_o = last_bit && (slot_q == num_words_i);
        bit_nxt_o   = bit_q;
        slot_nxt_o  = slot_q;
        if (clr_i) begin
            bit_nxt_o  = '0;
            slot_nxt_o = '0;
        end else if (last_bit) begin
            bit_nxt_o  = '0;
            slot_nxt_o = (slot_q == num_words_i) ? '0 : slot_q + 1'b1;
        end else begin
            bit_nxt_o = bit_q + 1'b1;
        end
    end

    // Position registers
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bit_q  <= '0;
            slot_q <= '0;
        end else begin
            bit_q  <= bit_nxt_o;
            slot_q <= slot_nxt_o;
        end
    end

endmodule

// File: rtl/i2s_tdm_ws_gen.sv
// rtl/i2s_tdm_ws_gen.sv - I2S/LJ/DSP word-select and frame-sync generator (optional SETUP via I2S_WS_SETUP_EN)
module i2s_tdm_ws_gen
    import i2s_ws_pkg::*;
#(
    parameter int MAX_BITS_W  = DEF_MAX_BITS_W,
    parameter int MAX_SLOTS_W = DEF_MAX_SLOTS_W,
    parameter int SETUP_W     = DEF_SETUP_W
) (
    input  logic                              sck_i,
    input  logic                              rstn_i,
    input  logic                              cfg_en_i,
    input  logic [1:0]                        cfg_mode_i,
    input  logic [MAX_BITS_W-1:0]             cfg_num_bits_i,
    input  logic [MAX_SLOTS_W-1:0]            cfg_num_words_i,
    input  logic [MAX_BITS_W+MAX_SLOTS_W-1:0] cfg_pulse_len_i,
`ifdef I2S_WS_SETUP_EN
    input  logic [SETUP_W-1:0]                cfg_setup_time_i,
`endif
    output logic                              ws_o,
    output logic [MAX_SLOTS_W-1:0]            slot_o,
    output logic                              frame_start_o,
    output logic                              busy_o
);

    localparam int PLW = MAX_BITS_W + MAX_SLOTS_W;
    localparam int PW  = PLW + 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
`ifdef I2S_WS_SETUP_EN
    localparam logic [1:0] ST_SETUP = SETUP;
`endif

    logic [1:0]             state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [MAX_BITS_W-1:0]  nbits_q, nbits_d;
    logic [MAX_SLOTS_W-1:0] nwords_q, nwords_d;
    logic [PLW-1:0]         pulse_q, pulse_d;
    logic                   ws_q, ws_d;
    logic [MAX_SLOTS_W-1:0] slot_q, slot_d;
    logic                   fs_q, fs_d;
`ifdef I2S_WS_SETUP_EN
    logic [SETUP_W-1:0]     setup_q, setup_d;
`endif

    logic                   shadow_load;
    logic                   cnt_clr;
    logic [MAX_BITS_W-1:0]  b_nxt;
    logic [MAX_SLOTS_W-1:0] s_nxt;
    logic                   frame_end;
    logic [MAX_SLOTS_W-1:0] s_look;
    logic [PW-1:0]          bits_ext, words_ext, len_d, p_d;

    // Counters run on the shadow config of the frame in progress
    i2s_ws_frame_cnt #(
        .BITS_W  (MAX_BITS_W),
        .SLOTS_W (MAX_SLOTS_W)
    ) u_frame_cnt (
        .sck_i       (sck_i),
        .rstn_i      (rstn_i),
        .clr_i       (cnt_clr),
        .num_bits_i  (nbits_q),
        .num_words_i (nwords_q),
        .bit_nxt_o   (b_nxt),
        .slot_nxt_o  (s_nxt),
        .frame_end_o (frame_end)
    );

    // Control FSM: enable starts a run, disable drains to the end of the frame
    always_comb begin
        state_d = state_q;
`ifdef I2S_WS_SETUP_EN
        setup_d = setup_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_en_i) begin
`ifdef I2S_WS_SETUP_EN
                    if (cfg_setup_time_i != '0) begin
                        state_d = ST_SETUP;
                        setup_d = cfg_setup_time_i - 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end
            end
`ifdef I2S_WS_SETUP_EN
            ST_SETUP: begin
                if (!cfg_en_i) begin
                    state_d = ST_IDLE;
                end else if (setup_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    setup_d = setup_q - 1'b1;
                end
            end
`endif
            ST_RUN: begin
                if (frame_end && !cfg_en_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadows follow cfg only at RUN entry and at frame wrap
    always_comb begin
        shadow_load = (state_d == ST_RUN) && ((state_q != ST_RUN) || frame_end);
        cnt_clr     = !((state_q == ST_RUN) && (state_d == ST_RUN));
        mode_d      = shadow_load ? cfg_mode_i      : mode_q;
        nbits_d     = shadow_load ? cfg_num_bits_i  : nbits_q;
        nwords_d    = shadow_load ? cfg_num_words_i : nwords_q;
        pulse_d     = shadow_load ? cfg_pulse_len_i : pulse_q;
    end

    // Output values for the next cycle's position, so the pins are registered
    always_comb begin
        bits_ext  = PW'(nbits_d) + PW'(1);
        words_ext = PW'(nwords_d) + PW'(1);
        len_d     = bits_ext * words_ext;
        p_d       = PW'(s_nxt) * bits_ext + PW'(b_nxt);
        // I2S leads by one bit: look at the slot of the following position
        if (b_nxt == nbits_d) begin
            s_look = (s_nxt == nwords_d) ? '0 : s_nxt + 1'b1;
        end else begin
            s_look = s_nxt;
        end
        ws_d   = 1'b0;
        slot_d = '0;
        fs_d   = 1'b0;
        if (state_d == ST_RUN) begin
            slot_d = s_nxt;
            fs_d   = (p_d == '0);
            case (mode_d)
                I2S:       ws_d = s_look[0];
                LJ:        ws_d = ~s_nxt[0];
                DSP_SHORT: ws_d = (p_d == '0);
                DSP_LONG:  ws_d = (len_d == PW'(1)) ||
                                  ((p_d <= PW'(pulse_d)) && (p_d != len_d - 1'b1));
                default:   ws_d = 1'b0;
            endcase
        end
    end

    // State, shadow and output registers
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            nbits_q  <= '0;
            nwords_q <= '0;
            pulse_q  <= '0;
            ws_q     <= 1'b0;
            slot_q   <= '0;
            fs_q     <= 1'b0;
`ifdef I2S_WS_SETUP_EN
            setup_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            nbits_q  <= nbits_d;
            nwords_q <= nwords_d;
            pulse_q  <= pulse_d;
            ws_q     <= ws_d;
            slot_q   <= slot_d;
            fs_q     <= fs_d;
`ifdef I2S_WS_SETUP_EN
            setup_q  <= setup_d;
`endif
        end
    end

    assign ws_o          = ws_q;
    assign slot_o        = slot_q;
    assign frame_start_o = fs_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_tdm_ws_gen.sv
// tb/tb_i2s_tdm_ws_gen.sv - directed self-checking bench for i2s_tdm_ws_gen
module tb_i2s_tdm_ws_gen;

    logic       sck;
    logic       rstn;
    logic       en;
    logic [1:0] mode;
    logic [4:0] nb;
    logic [3:0] nw;
    logic [8:0] pl;
`ifdef I2S_WS_SETUP_EN
    logic [15:0] st;
`endif
    logic       ws;
    logic [3:0] slot;
    logic       fs;
    logic       busy;

    int total = 0;
    int bad   = 0;

    i2s_tdm_ws_gen dut (
        .sck_i            (sck),
        .rstn_i           (rstn),
        .cfg_en_i         (en),
        .cfg_mode_i       (mode),
        .cfg_num_bits_i   (nb),
        .cfg_num_words_i  (nw),
        .cfg_pulse_len_i  (pl),
`ifdef I2S_WS_SETUP_EN
        .cfg_setup_time_i (st),
`endif
        .ws_o             (ws),
        .slot_o           (slot),
        .frame_start_o    (fs),
        .busy_o           (busy)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_gen();
        en = 1'b0;
        repeat (40) @(negedge sck);
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; mode = 2'b00; nb = '0; nw = '0; pl = '0;
`ifdef I2S_WS_SETUP_EN
        st = '0;
`endif
        repeat (2) @(negedge sck);
        total++;
        if ({ws, slot, fs, busy} !== 7'd0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0000000", {ws, slot, fs, busy});
        end
        rstn = 1'b1;
        repeat (3) @(negedge sck);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_no_autostart busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_dsp_short();
        mode = 2'b10; nb = 5'd15; nw = 4'd1; en = 1'b1;
        @(negedge sck);
        for (int p = 0; p < 64; p++) begin
            total++;
            if (ws !== (p % 32 == 0) || fs !== (p % 32 == 0) || slot !== 4'((p / 16) % 2) || busy !== 1'b1) begin
                bad++; $display("FAIL dsp_short p=%0d got ws=%b fs=%b slot=%0d busy=%b exp ws=fs=%b slot=%0d busy=1",
                                p, ws, fs, slot, busy, (p % 32 == 0), (p / 16) % 2);
            end
            @(negedge sck);
        end
        idle_gen();
    endtask

    task automatic test_dsp_long();
        int highs;
        mode = 2'b11; nb = 5'd7; nw = 4'd3; pl = 9'd4; en = 1'b1;
        @(negedge sck);
        highs = 0;
        for (int p = 0; p < 64; p++) begin
            if (p == 32) begin
                total++;
                if (highs !== 5) begin
                    bad++; $display("FAIL dsp_long_pl4_count got=%0d exp=5", highs);
                end
                highs = 0;
            end
            total++;
            if (ws !== ((p < 32) ? (p <= 4) : (p % 32 <= 30))) begin
                bad++; $display("FAIL dsp_long p=%0d got ws=%b exp=%b", p, ws, ((p < 32) ? (p <= 4) : (p % 32 <= 30)));
            end
            if (ws === 1'b1) highs++;
            if (p == 10) pl = 9'd40;
            @(negedge sck);
        end
        total++;
        if (highs !== 31) begin
            bad++; $display("FAIL dsp_long_pl40_count got=%0d exp=31", highs);
        end
        idle_gen();
    endtask

    task automatic test_i2s();
        mode = 2'b00; nb = 5'd15; nw = 4'd1; en = 1'b1;
        @(negedge sck);
        for (int p = 0; p < 64; p++) begin
            total++;
            if (ws !== 1'(((p + 1) % 32) / 16) || fs !== (p % 32 == 0)) begin
                bad++; $display("FAIL i2s p=%0d got ws=%b fs=%b exp ws=%0d fs=%b", p, ws, fs, ((p + 1) % 32) / 16, (p % 32 == 0));
            end
            @(negedge sck);
        end
        idle_gen();
    endtask

    task automatic test_lj();
        mode = 2'b01; nb = 5'd15; nw = 4'd1; en = 1'b1;
        @(negedge sck);
        for (int p = 0; p < 64; p++) begin
            total++;
            if (ws !== (p % 32 < 16) || slot !== 4'((p / 16) % 2)) begin
                bad++; $display("FAIL lj p=%0d got ws=%b slot=%0d exp ws=%b slot=%0d", p, ws, slot, (p % 32 < 16), (p / 16) % 2);
            end
            @(negedge sck);
        end
        idle_gen();
    endtask

    task automatic test_degenerate();
        mode = 2'b10; nb = 5'd0; nw = 4'd0; en = 1'b1;
        @(negedge sck);
        for (int c = 0; c < 8; c++) begin
            total++;
            if (ws !== 1'b1 || fs !== 1'b1 || busy !== 1'b1) begin
                bad++; $display("FAIL degenerate c=%0d got ws=%b fs=%b busy=%b exp 1 1 1", c, ws, fs, busy);
            end
            if (c == 3) mode = 2'b11;
            @(negedge sck);
        end
        en = 1'b0;
        @(negedge sck);
        total++;
        if (busy !== 1'b0 || ws !== 1'b0) begin
            bad++; $display("FAIL degenerate_stop got busy=%b ws=%b exp 0 0", busy, ws);
        end
        idle_gen();
    endtask

    task automatic test_drain();
        mode = 2'b10; nb = 5'd7; nw = 4'd3; en = 1'b1;
        @(negedge sck);
        for (int p = 0; p < 32; p++) begin
            total++;
            if (busy !== 1'b1 || ws !== (p == 0)) begin
                bad++; $display("FAIL drain p=%0d got busy=%b ws=%b exp busy=1 ws=%b", p, busy, ws, (p == 0));
            end
            if (p == 5) en = 1'b0;
            @(negedge sck);
        end
        total++;
        if (busy !== 1'b0 || ws !== 1'b0 || slot !== 4'd0 || fs !== 1'b0) begin
            bad++; $display("FAIL drain_idle got busy=%b ws=%b slot=%0d fs=%b exp all 0", busy, ws, slot, fs);
        end
        idle_gen();
    endtask

    task automatic test_back_to_back();
        mode = 2'b10; nb = 5'd7; nw = 4'd3; en = 1'b1;
        @(negedge sck);
        for (int p = 0; p < 33; p++) begin
            total++;
            if (busy !== 1'b1 || fs !== (p % 32 == 0)) begin
                bad++; $display("FAIL back_to_back p=%0d got busy=%b fs=%b exp busy=1 fs=%b", p, busy, fs, (p % 32 == 0));
            end
            if (p == 5) en = 1'b0;
            if (p == 20) en = 1'b1;
            @(negedge sck);
        end
        idle_gen();
    endtask

    task automatic test_shadow();
        int exp_slot;
        mode = 2'b10; nb = 5'd15; nw = 4'd1; en = 1'b1;
        @(negedge sck);
        for (int c = 0; c < 49; c++) begin
            exp_slot = (c < 32) ? (c / 16) % 2 : ((c - 32) % 16) / 8;
            total++;
            if (fs !== (c == 0 || c == 32 || c == 48) || slot !== 4'(exp_slot)) begin
                bad++; $display("FAIL shadow c=%0d got fs=%b slot=%0d exp fs=%b slot=%0d",
                                c, fs, slot, (c == 0 || c == 32 || c == 48), exp_slot);
            end
            if (c == 10) nb = 5'd7;
            @(negedge sck);
        end
        idle_gen();
    endtask

    task automatic test_reset_mid();
        mode = 2'b00; nb = 5'd7; nw = 4'd3; en = 1'b1;
        @(negedge sck);
        repeat (10) @(negedge sck);
        total++;
        if (ws !== 1'b1 || slot !== 4'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL reset_mid_pre got ws=%b slot=%0d busy=%b exp 1 1 1", ws, slot, busy);
        end
        #2 rstn = 1'b0; en = 1'b0;
        #1;
        total++;
        if ({ws, slot, fs, busy} !== 7'd0) begin
            bad++; $display("FAIL reset_mid_async got=%b exp=0000000", {ws, slot, fs, busy});
        end
        @(negedge sck);
        rstn = 1'b1;
        repeat (3) @(negedge sck);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_mid_stay_idle busy got=%b exp=0", busy);
        end
        en = 1'b1;
        @(negedge sck);
        total++;
        if (fs !== 1'b1 || busy !== 1'b1 || slot !== 4'd0) begin
            bad++; $display("FAIL reset_mid_restart got fs=%b busy=%b slot=%0d exp 1 1 0", fs, busy, slot);
        end
        idle_gen();
    endtask

`ifdef I2S_WS_SETUP_EN
    task automatic test_setup();
        mode = 2'b10; nb = 5'd7; nw = 4'd3; st = 16'd3; en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge sck);
            total++;
            if (busy !== 1'b1 || ws !== 1'b0 || fs !== 1'b0) begin
                bad++; $display("FAIL setup_wait c=%0d got busy=%b ws=%b fs=%b exp 1 0 0", c, busy, ws, fs);
            end
        end
        @(negedge sck);
        for (int p = 0; p < 32; p++) begin
            total++;
            if (busy !== 1'b1 || fs !== (p == 0) || ws !== (p == 0)) begin
                bad++; $display("FAIL setup_run p=%0d got busy=%b fs=%b ws=%b exp busy=1 fs=ws=%b", p, busy, fs, ws, (p == 0));
            end
            if (p == 5) en = 1'b0;
            @(negedge sck);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL setup_drain busy got=%b exp=0", busy);
        end
        en = 1'b1;
        @(negedge sck);
        en = 1'b0;
        @(negedge sck);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL setup_abort busy got=%b exp=0", busy);
        end
        st = 16'd0;
        idle_gen();
    endtask
`endif

    initial begin
        test_reset();
        test_dsp_short();
        test_dsp_long();
        test_i2s();
        test_lj();
        test_degenerate();
        test_drain();
        test_back_to_back();
        test_shadow();
        test_reset_mid();
`ifdef I2S_WS_SETUP_EN
        test_setup();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
